// File: rtl/amount_bcd_conv_pkg.sv
// Shared types and constants for the jiao-to-BCD converter feeding the seg driver.
// Holds the FSM encoding, the digit width, and helpers that size the saturation logic.
package amount_bcd_conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam int BCD_W = 4;

   // Packed BCD word with the lowest `digits` nibbles set to 9.
   function automatic logic [63:0] sat_value(input int digits);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < digits; i++) r[i*BCD_W +: BCD_W] = 4'd9;
      return r;
   endfunction

   // Largest amount that fits in `digits` decimal digits (10^digits - 1).
   function automatic logic [63:0] max_value(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/amount_bcd_conv_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
   input  logic [3:0] digit,
   input  logic [3:0] adjusted_digit_unused_guard,
   output logic [3:0] adjusted
);
   assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

// File: rtl/amount_bcd_conv.sv
// Iterative binary-to-BCD converter (one bit per clock) with start/busy/done handshake,
// leading-zero blanking that never blanks the decimal-point digit or below, and saturation.
module amount_bcd_conv #(
   parameter int BIN_W  = 20,
   parameter int DIGITS = 6,
   parameter int DP_POS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin_in,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]   blank,
   output logic                ovf
);
   import amount_bcd_conv_pkg::*;

   localparam int                ACC_W     = BCD_W * DIGITS;
   localparam int                CNT_W     = $clog2(BIN_W + 1);
   localparam logic [ACC_W-1:0]  SAT_VAL   = ACC_W'(sat_value(DIGITS));
   localparam logic [63:0]       MAX_VAL   = max_value(DIGITS);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'((1 << (DP_POS + 1)) - 1);

   if (((64'd1 << BIN_W) - 64'd1) > (64'd1 << ACC_W)) begin : g_width_chk
      $error("amount_bcd_conv: BIN_W too wide for a %0d-digit BCD accumulator", DIGITS);
   end

   state_t             state;
   logic [BIN_W-1:0]   bin_sr;
   logic [ACC_W-1:0]   bcd_acc;
   logic [ACC_W-1:0]   adj;
   logic [CNT_W-1:0]   bit_cnt;
   logic               sat;
   logic               over_range;
   logic               zero_run;
   logic [DIGITS-1:0]  blank_nxt;

   assign over_range = (64'(bin_in) > MAX_VAL);

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit                      (bcd_acc[g*BCD_W +: BCD_W]),
         .adjusted_digit_unused_guard(4'd0),
         .adjusted                   (adj[g*BCD_W +: BCD_W])
      );
   end

   // NOTE: every variable written here is given a value before the loop, so no latch is inferred.
   always_comb begin
      zero_run  = 1'b1;
      blank_nxt = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run & (bcd_acc[i*BCD_W +: BCD_W] == 4'd0);
         blank_nxt[i] = (i > DP_POS) && zero_run;
      end
   end

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         bin_sr  <= '0;
         bcd_acc <= '0;
         bit_cnt <= '0;
         sat     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         blank   <= BLANK_RST;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A start coinciding with the done pulse is dropped, not queued.
               if (start && !done) begin
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
                  if (over_range) begin
                     sat     <= 1'b1;
                     bcd_acc <= SAT_VAL;
                     bin_sr  <= '0;
                  end else begin
                     sat     <= 1'b0;
                     bcd_acc <= '0;
                     bin_sr  <= bin_in;
                  end
               end
            end
            ST_SHIFT: begin
               // Saturated requests hold the nines for one cycle so done lands two edges after start.
               if (sat) begin
                  state <= ST_DONE;
               end else begin
                  {bcd_acc, bin_sr} <= {adj[ACC_W-2:0], bin_sr, 1'b0};
                  bit_cnt           <= bit_cnt + 1'b1;
                  if (bit_cnt == CNT_W'(BIN_W - 1)) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               bcd_out <= bcd_acc;
               blank   <= blank_nxt;
               ovf     <= sat;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_amount_bcd_conv.sv
// Self-checking bench: directed handshake cases plus random amounts checked against a decimal model.
module tb_amount_bcd_conv;

   localparam int BIN_W  = 20;
   localparam int DIGITS = 6;
   localparam int DP_POS = 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [BIN_W-1:0]    bin_in;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank;
   logic                ovf;

   int checks = 0;
   int errors = 0;

   amount_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS), .DP_POS(DP_POS)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bin_in (bin_in),
      .busy   (busy),
      .done   (done),
      .bcd_out(bcd_out),
      .blank  (blank),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits by division; over-range amounts saturate to all nines.
   function automatic logic [23:0] ref_bcd(input longint v);
      logic [23:0] r;
      longint      p;
      if (v > 999999) v = 999999;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Digit i and everything above it is zero exactly when v < 10^i.
   function automatic logic [5:0] ref_blank(input longint v);
      logic [5:0] b;
      longint     p;
      if (v > 999999) v = 999999;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         b[i] = (i > DP_POS) && (v < p);
         p = p * 10;
      end
      return b;
   endfunction

   task automatic convert(input logic [BIN_W-1:0] v, input bit scramble,
                          output int lat, output int busy_cnt, output int done_cnt);
      @(negedge clk);
      bin_in = v;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      if (scramble) bin_in = BIN_W'($urandom);
      lat      = -1;
      busy_cnt = int'(busy);
      done_cnt = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat      = n;
            done_cnt = 1;
            break;
         end
         busy_cnt += int'(busy);
      end
      @(posedge clk);
      #1;
      done_cnt += int'(done);
   endtask

   task automatic run_check(input string tag, input logic [BIN_W-1:0] v, input bit scramble);
      int lat, busy_cnt, done_cnt, exp_lat;
      exp_lat = (longint'(v) > 999999) ? 2 : BIN_W + 1;
      convert(v, scramble, lat, busy_cnt, done_cnt);
      check({tag, "_lat"},   lat, exp_lat);
      check({tag, "_busy"},  busy_cnt, exp_lat);
      check({tag, "_done"},  done_cnt, 1);
      check({tag, "_bcd"},   bcd_out, ref_bcd(longint'(v)));
      check({tag, "_blank"}, blank, ref_blank(longint'(v)));
      check({tag, "_ovf"},   ovf, (longint'(v) > 999999));
   endtask

   initial begin
      int  dc;
      bit  seen;

      rst    = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      #12;
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_ovf",   ovf, 0);
      check("rst_bcd",   bcd_out, 0);
      check("rst_blank", blank, 6'b111100);
      @(negedge clk);
      rst = 1'b0;

      run_check("zero",   20'd0,       1'b0);
      run_check("v206",   20'd206,     1'b0);
      run_check("v999999", 20'd999999, 1'b0);
      run_check("v1e6",   20'd1000000, 1'b0);
      run_check("v5",     20'd5,       1'b0);

      // Starts during SHIFT and during the done pulse must both be dropped.
      @(negedge clk);
      bin_in = 20'd15;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      bin_in = 20'd77;
      dc     = 0;
      seen   = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         dc += int'(done);
         if (n == 3) start = 1'b1;
         else if (done && !seen) begin
            seen  = 1'b1;
            start = 1'b1;
         end else start = 1'b0;
      end
      start = 1'b0;
      check("ign_done_cnt", dc, 1);
      check("ign_bcd",      bcd_out, 24'h000015);
      check("ign_busy",     busy, 0);

      // Reset in the middle of a conversion aborts it with no done.
      @(negedge clk);
      bin_in = 20'd1234;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_busy",  busy, 0);
      check("mid_rst_bcd",   bcd_out, 0);
      check("mid_rst_done",  done, 0);
      check("mid_rst_blank", blank, 6'b111100);
      @(negedge clk);
      rst = 1'b0;
      dc  = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         dc += int'(done);
      end
      check("mid_rst_no_done", dc, 0);
      run_check("v1234", 20'd1234, 1'b0);

      for (int it = 0; it < 1000; it++) begin
         run_check("rand", BIN_W'($urandom_range(0, 999999)), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
